// File: rtl/vec_pkg.sv
// Shared mode encoding for the vector reorder pipeline.
// Latency: none (types and constants only). Backpressure: not applicable.
package vec_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS   = 2'b00;
  localparam mode_t MODE_BITREV = 2'b01;
  localparam mode_t MODE_GRPREV = 2'b10;
  localparam mode_t MODE_INGRP  = 2'b11;

endpackage

// File: rtl/vec_reorder.sv
// Combinational WIDTH-bit reorder: pass, bit-reverse, group-order reverse, in-group bit-reverse.
// Latency: 0 cycles (pure wiring plus a 4:1 mux).
// Backpressure: none, has no handshake of its own.
module vec_reorder
  import vec_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int GROUP = 4
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  output logic [WIDTH-1:0] reordered
);

  localparam int N = WIDTH / GROUP;

  if (WIDTH < 2 || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("vec_reorder: WIDTH must be >= 2 and a multiple of GROUP");
  end

  logic [WIDTH-1:0] bitrev;
  logic [WIDTH-1:0] grprev;
  logic [WIDTH-1:0] ingrp;

  // Bit i sits at offset k inside group g.
  for (genvar g = 0; g < N; g++) begin : g_grp
    for (genvar k = 0; k < GROUP; k++) begin : g_bit
      assign bitrev[g*GROUP+k] = data[WIDTH-1-(g*GROUP+k)];
      assign grprev[g*GROUP+k] = data[(N-1-g)*GROUP+k];
      assign ingrp[g*GROUP+k]  = data[g*GROUP+GROUP-1-k];
    end
  end

  always_comb begin
    reordered = data;
    case (mode)
      MODE_BITREV: reordered = bitrev;
      MODE_GRPREV: reordered = grprev;
      MODE_INGRP:  reordered = ingrp;
      default:     reordered = data;
    endcase
  end

endmodule

// File: rtl/vec_reverse_pipe.sv
// Registered vector reorder stage with transfer counter; out_parity exists when VEC_REVERSE_PARITY_EN is defined.
// Latency: 1 cycle, full throughput with out_ready held high.
// Backpressure: in_ready = !out_valid || out_ready; the held beat is frozen while stalled.
module vec_reverse_pipe
  import vec_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int GROUP = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  mode_t            in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output mode_t            out_mode,
`ifdef VEC_REVERSE_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] reordered;
  logic             accept;
  logic             out_xfer;

  vec_reorder #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_reorder (
    .data      (in_data),
    .mode      (in_mode),
    .reordered (reordered)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A new beat replacing a departing one keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= MODE_PASS;
      xfer_cnt  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= reordered;
        out_mode  <= in_mode;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

`ifdef VEC_REVERSE_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^reordered;
    end
  end
`endif

endmodule
